// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V style datapath.
// Moore outputs per state, with a few outputs qualified by mem_ready or zero.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t state_q;
  state_t state_n;
  state_t cur;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECR;
          OP_ITYPE:          state_n = S_EXECI;
          OP_JAL:            state_n = S_JAL;
          OP_BEQ:            state_n = S_BEQ;
          default:           state_n = S_FETCH;
        endcase
      end
      S_MEMADR:   state_n = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_JAL:      state_n = S_ALUWB;
      S_BEQ:      state_n = S_FETCH;
      default:    state_n = S_FETCH;
    endcase
  end

  // While reset is held the outputs present the FETCH set, so nothing
  // downstream sees a stale state before the synchronous reset lands.
  assign cur   = reset ? state_q : S_FETCH;
  assign state = cur;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready & reset;
        pc_write   = mem_ready & reset;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: ;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction class is
// expanded into its expected state path and checked cycle by cycle.
module tb_multicycle_control;

  logic       clock;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_done, illegal;
  logic [3:0] state;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction classes
  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BEQ = 5, C_ILL = 6;

  wire [19:0] act = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
                     alu_src_a, alu_src_b, alu_op, result_src, instr_done, illegal, state};

  // Expected control word for a state, from the per-state output table.
  function automatic logic [19:0] expv(int st, bit mr, bit z, bit ill);
    logic pw, iw, rw, mrd, mw, as, dn, il;
    logic [1:0] a, b, op, rs;
    {pw, iw, rw, mrd, mw, as, dn, il} = '0;
    {a, b, op, rs} = '0;
    case (st)
      0:  begin mrd = 1; b = 2; rs = 2; pw = mr; iw = mr; end
      1:  begin a = 1; b = 1; dn = ill; il = ill; end
      2:  begin a = 2; b = 1; end
      3:  begin mrd = 1; as = 1; end
      4:  begin rs = 1; rw = 1; dn = 1; end
      5:  begin mw = 1; as = 1; dn = mr; end
      6:  begin a = 2; op = 2; end
      7:  begin rw = 1; dn = 1; end
      8:  begin a = 2; b = 1; op = 2; end
      9:  begin a = 1; b = 2; pw = 1; end
      10: begin a = 2; op = 1; pw = z; dn = 1; end
      default: ;
    endcase
    return {pw, iw, rw, mrd, mw, as, a, b, op, rs, dn, il, 4'(st)};
  endfunction

  function automatic logic [6:0] class_op(int cls);
    logic [6:0] o;
    case (cls)
      C_LOAD:  o = 7'b0000011;
      C_STORE: o = 7'b0100011;
      C_R:     o = 7'b0110011;
      C_I:     o = 7'b0010011;
      C_JAL:   o = 7'b1101111;
      C_BEQ:   o = 7'b1100011;
      default: begin
        do o = 7'($urandom);
        while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011);
      end
    endcase
    return o;
  endfunction

  // Invariants: never read+write memory, never write reg+pc together.
  always @(negedge clock) begin
    if (mon_en) begin
      n_cmp++;
      if ((mem_read && mem_write) || (reg_write && pc_write)) begin
        n_fail++;
        $display("FAIL exclusive_outputs t=%0t: mem_read=%b mem_write=%b reg_write=%b pc_write=%b required no overlapping pair",
                 $time, mem_read, mem_write, reg_write, pc_write);
      end
    end
  end

  // Entered just after a rising edge; drives inputs, checks mid-cycle, advances.
  task automatic cycle(string name, int st, bit mr, bit z, logic [6:0] op, bit ill, bit rst);
    logic [19:0] e;
    reset = rst; mem_ready = mr; zero = z; opcode = op;
    @(negedge clock);
    e = rst ? expv(st, mr, z, ill) : expv(0, 0, 0, 0);
    n_cmp++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h (state %0d) required %h (state %0d)",
               name, $time, act, state, e, st);
    end
    @(posedge clock); #1;
  endtask

  // Expand one instruction into its state path and check each cycle.
  task automatic run_instr(string name, int cls, bit z, int fw, int mw);
    int sq[$];
    bit mq[$];
    logic [6:0] op;
    op = class_op(cls);
    for (int k = 0; k < fw; k++) begin sq.push_back(0); mq.push_back(0); end
    sq.push_back(0); mq.push_back(1);
    sq.push_back(1); mq.push_back(1'($urandom));
    case (cls)
      C_LOAD, C_STORE: begin
        int ms;
        ms = (cls == C_LOAD) ? 3 : 5;
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int k = 0; k < mw; k++) begin sq.push_back(ms); mq.push_back(0); end
        sq.push_back(ms); mq.push_back(1);
        if (cls == C_LOAD) begin sq.push_back(4); mq.push_back(1'($urandom)); end
      end
      C_R:   begin sq.push_back(6);  sq.push_back(7); mq.push_back(1'($urandom)); mq.push_back(1'($urandom)); end
      C_I:   begin sq.push_back(8);  sq.push_back(7); mq.push_back(1'($urandom)); mq.push_back(1'($urandom)); end
      C_JAL: begin sq.push_back(9);  sq.push_back(7); mq.push_back(1'($urandom)); mq.push_back(1'($urandom)); end
      C_BEQ: begin sq.push_back(10); mq.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      logic [6:0] o;
      bit zz;
      o  = (sq[i] == 1 || sq[i] == 2) ? op : 7'($urandom);
      zz = (sq[i] == 10) ? z : 1'($urandom);
      cycle(name, sq[i], mq[i], zz, o, cls == C_ILL, 1'b1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle("reset_hold", 0, 1'($urandom), 1'($urandom), 7'($urandom), 0, 1'b0);
    cycle("reset_release", 0, 1'b0, 1'b0, 7'd0, 0, 1'b1);
  endtask

  task automatic test_rtype();  run_instr("rtype", C_R, 0, 0, 0); run_instr("itype", C_I, 0, 0, 0); endtask
  task automatic test_lw_wait(); run_instr("lw_wait", C_LOAD, 0, 2, 3); endtask
  task automatic test_beq();
    run_instr("beq_taken", C_BEQ, 1, 0, 0);
    run_instr("beq_not_taken", C_BEQ, 0, 0, 0);
  endtask
  task automatic test_jal_sw();
    run_instr("jal", C_JAL, 0, 0, 0);
    run_instr("sw", C_STORE, 0, 0, 0);
    run_instr("sw_wait", C_STORE, 0, 1, 2);
  endtask
  task automatic test_illegal();
    cycle("illegal_fetch", 0, 1'b1, 1'b0, 7'b1111111, 0, 1'b1);
    cycle("illegal_decode", 1, 1'b0, 1'b0, 7'b1111111, 1, 1'b1);
    cycle("illegal_back", 0, 1'b0, 1'b0, 7'b1111111, 0, 1'b1);
    run_instr("illegal_rand", C_ILL, 0, 0, 0);
  endtask

  // Reset while the memory is still stalling a store or load.
  task automatic test_reset_midwait(bit store);
    logic [6:0] op;
    int ms;
    op = store ? 7'b0100011 : 7'b0000011;
    ms = store ? 5 : 3;
    cycle("midwait_fetch", 0, 1'b1, 1'b0, op, 0, 1'b1);
    cycle("midwait_decode", 1, 1'b0, 1'b0, op, 0, 1'b1);
    cycle("midwait_memadr", 2, 1'b0, 1'b0, op, 0, 1'b1);
    cycle("midwait_stall", ms, 1'b0, 1'b0, op, 0, 1'b1);
    cycle("midwait_stall", ms, 1'b0, 1'b0, op, 0, 1'b1);
    cycle("midwait_reset_lo", 0, 1'b0, 1'b0, op, 0, 1'b0);
    cycle("midwait_reset_rdy", 0, 1'b1, 1'b0, op, 0, 1'b0);
    cycle("midwait_after", 0, 1'b0, 1'b0, op, 0, 1'b1);
    run_instr("midwait_next", C_R, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int cls;
      cls = int'($urandom_range(0, 6));
      run_instr("random", cls, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clock); #1;
    mon_en = 1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_jal_sw();
    test_illegal();
    test_reset_midwait(1'b1);
    test_reset_midwait(1'b0);
    test_random();
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
